// File: rtl/div_mod_top_level.sv
// Sequential signed divider / modulo unit.
// Operands are accepted while idle, their magnitudes are divided with a
// 32-step restoring shift-subtract, and the signed, saturated quotient or
// remainder is presented with a one-cycle valid_output pulse.
module div_mod_top_level (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    input  logic        mode,
    input  logic        valid_input,
    output logic        valid_output,
    output logic [16:0] final_output
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Working registers: quo starts as |dividend| and fills with quotient
    // bits from the right as the dividend bits shift out on the left.
    logic [31:0] quo;
    logic [16:0] rem;
    logic [16:0] dvs_mag;
    logic [5:0]  count;
    logic        mode_q;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    // Operand magnitudes are one bit wider than the operands so that
    // -2^31 and -2^15 negate without overflow.
    logic [32:0] dd_mag_w;
    logic [16:0] dv_mag_w;

    // Restoring step signals.
    logic [16:0] trial;
    logic [16:0] diff;
    logic        fits;

    // Result formatting signals.
    logic [33:0] q_wide;
    logic [33:0] q_signed;
    logic [16:0] r_signed;
    logic [16:0] result_next;

    // Absolute values of the incoming operands.
    always_comb begin
        dd_mag_w = dividend[31] ? (33'd0 - {dividend[31], dividend})
                                : {1'b0, dividend};
        dv_mag_w = divisor[15]  ? (17'd0 - {divisor[15], divisor})
                                : {1'b0, divisor};
    end

    // One restoring shift-subtract step: bring down the next dividend bit
    // and subtract the divisor if it fits. rem stays below the divisor
    // (at most 32768), so its low 16 bits plus the new bit never overflow.
    always_comb begin
        trial = {rem[15:0], quo[31]};
        fits  = (trial >= dvs_mag);
        diff  = trial - dvs_mag;
    end

    // State register.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: CALC runs 32 iterations, then one extra cycle to
    // reach DONE, giving a result pulse 34 edges after the accept.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (valid_input)    state_next = CALC;
            CALC:    if (count == 6'd32) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: apply signs, saturate the quotient, handle divide by zero.
    always_comb begin
        q_wide   = {2'b00, quo};
        q_signed = q_neg ? (34'd0 - q_wide) : q_wide;
        r_signed = r_neg ? (17'd0 - rem) : rem;

        if (mode_q) begin
            if (div_zero)
                result_next = r_neg ? 17'h10000 : 17'h0FFFF;
            else if ($signed(q_signed) > 34'sd65535)
                result_next = 17'h0FFFF;
            else if ($signed(q_signed) < -34'sd65536)
                result_next = 17'h10000;
            else
                result_next = q_signed[16:0];
        end else begin
            result_next = div_zero ? 17'd0 : r_signed;
        end
    end

    // Datapath registers: operand capture, iteration, and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo          <= '0;
            rem          <= '0;
            dvs_mag      <= '0;
            count        <= '0;
            mode_q       <= 1'b0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            div_zero     <= 1'b0;
            valid_output <= 1'b0;
            final_output <= '0;
        end else begin
            valid_output <= (state == DONE);
            case (state)
                IDLE: begin
                    if (valid_input) begin
                        quo      <= dd_mag_w[31:0];
                        rem      <= '0;
                        dvs_mag  <= dv_mag_w;
                        count    <= '0;
                        mode_q   <= mode;
                        q_neg    <= dividend[31] ^ divisor[15];
                        r_neg    <= dividend[31];
                        div_zero <= (divisor == 16'd0);
                    end
                end
                CALC: begin
                    if (count != 6'd32) begin
                        quo   <= {quo[30:0], fits};
                        rem   <= fits ? diff : trial;
                        count <= count + 6'd1;
                    end
                end
                DONE: begin
                    final_output <= result_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_mod_top_level.sv
// Directed bench for div_mod_top_level. Each issued operation pushes its
// expected result and expected pulse cycle to a queue; a monitor pops and
// compares whenever valid_output is seen.
module tb_div_mod_top_level;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        mode = 1'b0;
    logic        valid_input = 1'b0;
    logic        valid_output;
    logic [16:0] final_output;

    typedef struct {
        logic [16:0] res;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    div_mod_top_level dut (
        .clk          (clk),
        .reset        (reset),
        .dividend     (dividend),
        .divisor      (divisor),
        .mode         (mode),
        .valid_input  (valid_input),
        .valid_output (valid_output),
        .final_output (final_output)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every pulse must match the oldest expectation, in value and cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && valid_output) begin
            total++;
            assert (sb.size() > 0)
            else begin
                bad++;
                $error("FAIL unexpected_pulse cyc=%0d observed=%0d expected=no pulse",
                       cyc, $signed(final_output));
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                assert (final_output === e.res)
                else begin
                    bad++;
                    $error("FAIL %s result observed=%0d expected=%0d",
                           e.tag, $signed(final_output), $signed(e.res));
                end
                total++;
                assert (cyc === e.cyc)
                else begin
                    bad++;
                    $error("FAIL %s latency observed_cyc=%0d expected_cyc=%0d",
                           e.tag, cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Drive one operation for one cycle and record its expectation.
    task automatic issue(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                         input logic m, input int expv);
        exp_t e;
        @(negedge clk);
        dividend    = dd;
        divisor     = dv;
        mode        = m;
        valid_input = 1'b1;
        e.res = expv[16:0];
        e.cyc = cyc + 35;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        valid_input = 1'b0;
    endtask

    // Wait, with a bound, until the scoreboard drains.
    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("FAIL %s timeout observed_pending=%0d expected_pending=0", tag, sb.size());
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                       input logic m, input int expv);
        issue(tag, dd, dv, m, expv);
        wait_done(tag);
    endtask

    initial begin
        // Reset held with valid_input toggling: outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_input = ~valid_input;
            dividend    = 32'd100;
            divisor     = 16'd7;
            check("reset_valid", {16'd0, valid_output}, 17'd0);
            check("reset_result", final_output, 17'd0);
        end
        valid_input = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", {16'd0, valid_output}, 17'd0);

        run("div_m80_m3",   -32'sd80,  -16'sd3, 1'b1,  26);
        run("mod_m80_m3",   -32'sd80,  -16'sd3, 1'b0,  -2);
        run("div_100_7",     32'sd100,  16'sd7, 1'b1,  14);
        run("mod_100_7",     32'sd100,  16'sd7, 1'b0,   2);
        run("div_m7_2",     -32'sd7,    16'sd2, 1'b1,  -3);
        run("mod_m7_2",     -32'sd7,    16'sd2, 1'b0,  -1);
        run("div_7_m2",      32'sd7,   -16'sd2, 1'b1,  -3);
        run("mod_7_m2",      32'sd7,   -16'sd2, 1'b0,   1);
        run("div_5_0",       32'sd5,    16'sd0, 1'b1,  65535);
        run("div_m5_0",     -32'sd5,    16'sd0, 1'b1, -65536);
        run("mod_5_0",       32'sd5,    16'sd0, 1'b0,   0);
        run("div_max_1",     32'h7FFF_FFFF, 16'sd1, 1'b1, 65535);
        run("div_min_min",   32'h8000_0000, 16'h8000, 1'b1, 65535);
        run("mod_min_32767", 32'h8000_0000, 16'h7FFF, 1'b0, -2);
        run("div_m100_7",   -32'sd100,  16'sd7, 1'b1, -14);

        // Second request while busy is ignored: one pulse, first result only.
        issue("busy_first", 32'sd1000, 16'sd3, 1'b1, 333);
        repeat (5) @(negedge clk);
        dividend    = 32'sd9;
        divisor     = 16'sd2;
        mode        = 1'b0;
        valid_input = 1'b1;
        @(negedge clk);
        valid_input = 1'b0;
        wait_done("busy_first");
        repeat (40) @(negedge clk);
        check("busy_hold", final_output, 17'd333);

        // Reset at cycle 10 of CALC aborts without a pulse.
        issue("aborted", 32'sd50, 16'sd5, 1'b1, 10);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        check("abort_valid", {16'd0, valid_output}, 17'd0);
        check("abort_result", final_output, 17'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_quiet", final_output, 17'd0);

        run("after_abort", 32'sd50, 16'sd5, 1'b1, 10);
        run("after_abort_mod", -32'sd51, 16'sd5, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_mod_top_level.md
Name: div_mod_top_level

Overview:
Sequential signed integer divider/modulo unit. Takes a 32-bit signed dividend and a 16-bit signed divisor on a valid strobe. Returns either the quotient or the remainder as a 17-bit signed result, with a one-cycle valid pulse. It sits as a standalone arithmetic block; upstream logic issues one operation at a time.

Parameters:
None. Widths are fixed at 32/16/17.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
dividend  input  32  signed two's-complement dividend
divisor  input  16  signed two's-complement divisor
mode  input  1  1 = division (quotient), 0 = modulo (remainder)
valid_input  input  1  operands/mode valid; sampled only when idle
valid_output  output  1  one-cycle pulse: final_output carries a new result
final_output  output  17  signed result (quotient or remainder)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (port name reset).
- Reset (reset=0): FSM to IDLE; valid_output=0; final_output=0; all internal registers cleared. Reset mid-operation aborts it with no output pulse.
- FSM states and transitions:
  - IDLE -> CALC: on the rising edge where valid_input=1. Latch dividend, divisor and mode. Take absolute values and record the result signs.
  - CALC: restoring shift-subtract, one quotient bit per clock, 32 iterations on |dividend| / |divisor|.
  - CALC -> DONE: after the 32nd iteration.
  - DONE: apply the signs, saturate, register final_output, pulse valid_output. Then return to IDLE.
- Latency: valid_output is high for exactly one cycle, on the 34th rising edge after the edge that sampled valid_input. final_output holds its value until the next result or reset.
- While in CALC or DONE, valid_input is ignored (no queuing). The first accept is possible on the edge after the valid_output pulse.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend, with |remainder| < |divisor|.
  - Identity: dividend = quotient*divisor + remainder.
  - Negation handles -2^31 and -2^15 correctly; magnitudes use 33/17-bit internal width.
- Quotient saturation: results outside the 17-bit signed range saturate to +65535 or -65536. The remainder always fits.
- Divide by zero (divisor=0): quotient = +65535 if dividend >= 0, else -65536; remainder = 0. Normal latency and valid_output pulse.
- The sign extension of 17-bit final_output is a true signed value.

Test Plan:
- Reset: hold reset=0 for 5 cycles with valid_input toggling -> valid_output=0, final_output=0, no pulse.
- Divide: dividend=-80, divisor=-3, mode=1, valid_input for 1 cycle -> exactly 34 edges later valid_output=1 for one cycle, final_output=26.
- Modulo: dividend=-80, divisor=-3, mode=0 -> final_output=-2.
- Mixed-sign set:
  - 100/7 -> quotient 14, remainder 2.
  - -7/2 -> quotient -3, remainder -1.
  - 7/-2 -> quotient -3, remainder 1.
- Boundaries and busy handling:
  - divisor=0 with dividend=5 -> 65535; with dividend=-5 -> -65536; mode=0 -> 0.
  - 2147483647/1 -> 65535 (saturated).
  - -2147483648/-32768 -> 65536 saturates to 65535.
  - -2147483648/32767 with mode=0 -> -2.
  - Second valid_input asserted mid-CALC is ignored (single pulse, first result only).
- Reset mid-operation: assert reset at cycle 10 of CALC -> no valid_output; a new operation afterwards completes normally.
